// File: rtl/nibble_rx_pkg.sv
// Shared types and frame geometry for the nibble frame receiver.
package nibble_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam int DATA_BITS      = 4;
    localparam int FRAME_BITS     = 7;
    localparam int START_BIT_IDX  = 0;
    localparam int PARITY_BIT_IDX = 5;
    localparam int STOP_BIT_IDX   = 6;
    localparam int IDX_W          = $clog2(FRAME_BITS);

endpackage

// File: rtl/nibble_rx_bit_timer.sv
// Oversampling timer: counts clocks within a bit and tracks which frame bit is current.
module nibble_rx_bit_timer
    import nibble_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             sample_tick,
    output logic [IDX_W-1:0] bit_idx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // The start bit is sampled at mid-bit; every later bit is one full bit after the previous sample.
    assign sample_tick = (bit_idx == IDX_W'(START_BIT_IDX)) ? (cnt == HALF_LAST)
                                                            : (cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else if (sample_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nibble_frame_receiver.sv
// Serial frame receiver (start, 4 data LSB first, parity, stop) feeding the even-parity checker.
// Optional input synchronizer enabled by defining NIBBLE_RX_SYNC_EN.
module nibble_frame_receiver
    import nibble_rx_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial,
    input  logic rx_en,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic p,
    output logic frame_valid,
    output logic framing_err,
    output logic busy
);

    rx_state_t state, state_next;

    logic                 rx;
    logic                 rx_is_idle;
    logic                 sample_tick;
    logic                 timer_clear;
    logic                 shift_data;
    logic                 take_parity;
    logic                 load_frame;
    logic                 stop_err;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] data_sr;
    logic                 p_hold;

`ifdef NIBBLE_RX_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= {2{IDLE_LEVEL}};
        end else begin
            sync_ff <= {sync_ff[0], rx_serial};
        end
    end

    assign rx = sync_ff[1];
`else
    assign rx = rx_serial;
`endif

    assign rx_is_idle = (rx == IDLE_LEVEL);

    nibble_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .sample_tick(sample_tick),
        .bit_idx    (bit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer is held clear while idle so it restarts exactly on the start-bit edge.
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        shift_data  = 1'b0;
        take_parity = 1'b0;
        load_frame  = 1'b0;
        stop_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (rx_en && !rx_is_idle) state_next = ST_START;
            end
            ST_START: begin
                if (sample_tick) state_next = rx_is_idle ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                shift_data = sample_tick;
                if (sample_tick && bit_idx == IDX_W'(DATA_BITS)) state_next = ST_PARITY;
            end
            ST_PARITY: begin
                if (sample_tick && bit_idx == IDX_W'(PARITY_BIT_IDX)) begin
                    take_parity = 1'b1;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_tick && bit_idx == IDX_W'(STOP_BIT_IDX)) begin
                    load_frame = rx_is_idle;
                    stop_err   = !rx_is_idle;
                    state_next = rx_is_idle ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                timer_clear = 1'b1;
                if (rx_is_idle) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Holding registers collect the frame; a..p only change when a whole frame ends with a good stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sr     <= '0;
            p_hold      <= 1'b0;
            a           <= 1'b0;
            b           <= 1'b0;
            c           <= 1'b0;
            d           <= 1'b0;
            p           <= 1'b0;
            frame_valid <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            frame_valid <= load_frame;
            framing_err <= stop_err;
            if (shift_data) data_sr <= {rx, data_sr[DATA_BITS-1:1]};
            if (take_parity) p_hold <= rx;
            if (load_frame) begin
                a <= data_sr[0];
                b <= data_sr[1];
                c <= data_sr[2];
                d <= data_sr[3];
                p <= p_hold;
            end
        end
    end

endmodule

// File: tb/tb_nibble_frame_receiver.sv
// Scoreboard bench for nibble_frame_receiver (default build, CLKS_PER_BIT = 4).
module tb_nibble_frame_receiver;

    localparam int C         = 4;
    localparam int VALID_LAT = 6 * C + C / 2 + 1;

    logic clk = 1'b0;
    logic rst;
    logic rx_serial;
    logic rx_en;
    logic a, b, c, d, p;
    logic frame_valid, framing_err, busy;

    typedef struct {
        bit         err;
        logic [4:0] outs;
        int         cycle;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [4:0] last_good   = 5'b0;

    nibble_frame_receiver #(
        .CLKS_PER_BIT(C),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .rx_en      (rx_en),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .p          (p),
        .frame_valid(frame_valid),
        .framing_err(framing_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drives one frame starting at a negedge; T0 is the cycle in which the start bit first appears.
    task automatic applyStimulus(input logic [3:0] data, input logic par, input logic stop,
                                 input int stop_len);
        exp_t e;
        if (rx_en) begin
            e.err = (stop != 1'b1);
            if (!e.err) last_good = {data[0], data[1], data[2], data[3], par};
            e.outs  = last_good;
            e.cycle = cyc + VALID_LAT;
            sb.push_back(e);
        end
        rx_serial = 1'b0;
        @(negedge clk);
        checkOutput("busy_start", busy, rx_en);
        repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_serial = data[i];
            repeat (C) @(negedge clk);
        end
        rx_serial = par;
        repeat (C) @(negedge clk);
        rx_serial = stop;
        repeat (stop_len) @(negedge clk);
        checkOutput("busy_end", busy, rx_en && !stop);
        rx_serial = 1'b1;
    endtask

    // Every strobe must match the oldest outstanding expectation in kind, cycle and data.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_valid || framing_err) begin
                checkOutput("strobe_excl", frame_valid & framing_err, 0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe", {frame_valid, framing_err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("strobe_kind", {frame_valid, framing_err}, mon_e.err ? 2'b01 : 2'b10);
                    checkOutput("strobe_cycle", cyc, mon_e.cycle);
                    checkOutput("abcdp", {a, b, c, d, p}, mon_e.outs);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rdata;
        rst       = 1'b1;
        rx_serial = 1'b1;
        rx_en     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {a, b, c, d, p, frame_valid, framing_err, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] good frame");
        applyStimulus(4'b1101, 1'b1, 1'b1, C);
        repeat (3) @(negedge clk);

        $display("[TB] glitch");
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        checkOutput("glitch_busy", busy, 1);
        repeat (3) @(negedge clk);
        checkOutput("glitch_idle", busy, 0);
        checkOutput("glitch_hold", {a, b, c, d, p}, last_good);
        repeat (3) @(negedge clk);

        $display("[TB] framing error with held break");
        applyStimulus(4'b1100, 1'b0, 1'b0, 20);
        repeat (2) @(negedge clk);
        checkOutput("break_release", busy, 0);
        checkOutput("break_hold", {a, b, c, d, p}, last_good);
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-frame");
        rx_serial = 1'b0;
        repeat (C) @(negedge clk);
        rx_serial = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid", {a, b, c, d, p, frame_valid, framing_err, busy}, 0);
        last_good = 5'b0;
        repeat (2) @(negedge clk);
        applyStimulus(4'b1111, 1'b0, 1'b1, C);
        repeat (3) @(negedge clk);

        $display("[TB] back-to-back");
        applyStimulus(4'b0110, 1'b0, 1'b1, C - 1);
        applyStimulus(4'b1001, 1'b0, 1'b1, C);
        repeat (3) @(negedge clk);

        $display("[TB] receiver disabled");
        rx_en = 1'b0;
        applyStimulus(4'b0101, 1'b0, 1'b1, C);
        checkOutput("disabled_hold", {a, b, c, d, p}, last_good);
        rx_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] random frames");
        for (int i = 0; i < 6; i++) begin
            rdata = 4'($urandom_range(0, 15));
            applyStimulus(rdata, ^rdata, 1'b1, $urandom_range(C - 1, C));
        end

        repeat (40) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
